gpio_stream_capture: RTL

//  Parametrised, synthesizable GPIO capture unit. Samples processor GPIO writes (data qualified by enable),

---
 rtl/gpio_cap_pkg.sv | 16 +
 rtl/cap_sync_fifo.sv | 53 +++++
 rtl/gpio_stream_capture.sv | 139 +++++++++++++
 3 files changed

// File: rtl/gpio_cap_pkg.sv
// Shared types and helpers for the GPIO stream capture unit.
// Imported by the capture top and its FIFO.
package gpio_cap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE
  } cap_state_t;

  function automatic int chan_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cap_sync_fifo.sv
// Show-ahead synchronous FIFO.
// Accepts a push while full when a pop happens in the same cycle.
module cap_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gpio_stream_capture.sv
// Multi-channel GPIO write capture with round-robin arbitration,
// FIFO buffering and valid/ready streaming, stopping at a sample limit.
module gpio_stream_capture
  import gpio_cap_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CHANNELS     = 1,
  parameter int DEPTH        = 16,
  parameter int SAMPLE_LIMIT = 152100,
  parameter int CNT_W        = 18
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           arm,
  input  logic [CHANNELS*DATA_W-1:0]     gpio_data,
  input  logic [CHANNELS-1:0]            gpio_en,
  output logic [DATA_W-1:0]              out_data,
  output logic [chan_w(CHANNELS)-1:0]    out_chan,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CNT_W-1:0]               sample_count,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int CW = chan_w(CHANNELS);

  typedef struct packed {
    logic [CW-1:0]     chan;
    logic [DATA_W-1:0] data;
  } cap_entry_t;

  cap_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [CW-1:0] rr_q, rr_d;

  logic        win_vld;
  logic [CW-1:0] win;
  logic [DATA_W-1:0] win_data;
  logic        push, accept, pop, full, empty;
  cap_entry_t  wentry, rentry;

  // Two passes: channels at or after rr_q first, then the wrapped ones.
  always_comb begin
    win_vld  = 1'b0;
    win      = '0;
    win_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!win_vld && gpio_en[c] && CW'(c) >= rr_q) begin
        win_vld  = 1'b1;
        win      = CW'(c);
        win_data = gpio_data[c*DATA_W +: DATA_W];
      end
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (!win_vld && gpio_en[c] && CW'(c) < rr_q) begin
        win_vld  = 1'b1;
        win      = CW'(c);
        win_data = gpio_data[c*DATA_W +: DATA_W];
      end
    end
  end

  assign pop         = !empty && out_ready;
  assign push        = (state_q == CAPTURE) && win_vld;
  assign accept      = push && (!full || pop);
  assign wentry.chan = win;
  assign wentry.data = win_data;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    rr_d  = rr_q;
    if ((state_q == IDLE || state_q == DONE) && arm) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end
    if (push) begin
      rr_d = (win == CW'(CHANNELS-1)) ? '0 : win + CW'(1);
      if ($countones(gpio_en) > 1 || !accept) ovf_d = 1'b1;
      if (accept) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (arm) state_d = CAPTURE;
      CAPTURE: begin
        if (accept && cnt_d == CNT_W'(SAMPLE_LIMIT)) state_d = DRAIN;
      end
      DRAIN: if (empty) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CAPTURE) || (state_q == DRAIN);
    done = (state_q == DONE);
  end

  cap_sync_fifo #(
    .WIDTH($bits(cap_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .wdata(wentry),
    .pop  (pop),
    .rdata(rentry),
    .full (full),
    .empty(empty)
  );

  // Outputs read as zero while nothing is buffered.
  assign out_valid    = !empty;
  assign out_data     = out_valid ? rentry.data : '0;
  assign out_chan     = out_valid ? rentry.chan : '0;
  assign sample_count = cnt_q;
  assign overflow     = ovf_q;

endmodule
